// File: rtl/bin2bcd_param.sv
// Sequential double-dabble binary-to-BCD converter with overflow saturation.
// Optional macro BIN2BCD_SIGNED_EN: two's-complement input, magnitude converted, sign on neg.
module bin2bcd_param #(
  parameter int unsigned BIN_W  = 13,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done_tick,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                  neg
`endif
);

  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam int unsigned BcdW = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StOp, StDone} state_e;

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  shift_q, shift_d;
  logic [BcdW-1:0]   work_q, work_d, work_adj;
  logic              sticky_q, sticky_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic [BIN_W-1:0]  operand;

`ifdef BIN2BCD_SIGNED_EN
  logic sign_q, sign_d, neg_q, neg_d;
  // Unary minus in BIN_W bits maps the most negative value onto its own magnitude.
  assign operand = bin[BIN_W-1] ? -bin : bin;
`else
  assign operand = bin;
`endif

  always_comb begin
    for (int i = 0; i < int'(DIGITS); i++) begin
      work_adj[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3
                                                      : work_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    work_d   = work_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
    sign_d   = sign_q;
    neg_d    = neg_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_d  = operand;
          work_d   = '0;
          sticky_d = 1'b0;
          cnt_d    = CntW'(BIN_W);
`ifdef BIN2BCD_SIGNED_EN
          sign_d   = bin[BIN_W-1];
`endif
          state_d  = StOp;
        end
      end
      StOp: begin
        shift_d = {shift_q[BIN_W-2:0], 1'b0};
        work_d  = {work_adj[BcdW-2:0], shift_q[BIN_W-1]};
        // A bit leaving the top digit means the value no longer fits in DIGITS digits.
        if (work_adj[BcdW-1]) sticky_d = 1'b1;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StDone;
      end
      StDone: begin
        bcd_d   = sticky_q ? {DIGITS{4'h9}} : work_q;
        ovf_d   = sticky_q;
`ifdef BIN2BCD_SIGNED_EN
        neg_d   = sign_q;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      work_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      sign_q   <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      work_q   <= work_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
`ifdef BIN2BCD_SIGNED_EN
      sign_q   <= sign_d;
      neg_q    <= neg_d;
`endif
    end
  end

  assign ready     = (state_q == StIdle);
  assign done_tick = (state_q == StDone);
  assign overflow  = ovf_q;
  assign bcd       = bcd_q;
`ifdef BIN2BCD_SIGNED_EN
  assign neg       = neg_q;
`endif

endmodule

// File: tb/tb_bin2bcd_param.sv
// Scoreboard bench: two converters (wide and narrow digit count) share one stimulus stream;
// expected results come from decimal arithmetic on the accepted operand.
module tb_bin2bcd_param;

`ifdef BIN2BCD_SIGNED_EN
  localparam int unsigned BW = 8;
  localparam int unsigned DA = 3;
  localparam int unsigned DB = 2;
`else
  localparam int unsigned BW = 13;
  localparam int unsigned DA = 4;
  localparam int unsigned DB = 3;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] bin = '0;

  logic            ready_a, done_a, ovf_a, neg_a;
  logic            ready_b, done_b, ovf_b, neg_b;
  logic [4*DA-1:0] bcd_a;
  logic [4*DB-1:0] bcd_b;

  bin2bcd_param #(.BIN_W(BW), .DIGITS(DA)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start), .bin(bin), .ready(ready_a),
    .done_tick(done_a), .overflow(ovf_a), .bcd(bcd_a)
`ifdef BIN2BCD_SIGNED_EN
    , .neg(neg_a)
`endif
  );

  bin2bcd_param #(.BIN_W(BW), .DIGITS(DB)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start), .bin(bin), .ready(ready_b),
    .done_tick(done_b), .overflow(ovf_b), .bcd(bcd_b)
`ifdef BIN2BCD_SIGNED_EN
    , .neg(neg_b)
`endif
  );

`ifndef BIN2BCD_SIGNED_EN
  assign neg_a = 1'b0;
  assign neg_b = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int unsigned mag;
    bit          neg;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int   busy = 0;
  bit   rst_edge = 1'b0;
  bit   armed = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic int unsigned mag_of(logic [BW-1:0] v);
`ifdef BIN2BCD_SIGNED_EN
    return v[BW-1] ? ((1 << BW) - 32'(v)) : 32'(v);
`else
    return 32'(v);
`endif
  endfunction

  function automatic bit neg_of(logic [BW-1:0] v);
`ifdef BIN2BCD_SIGNED_EN
    return v[BW-1];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned limit_of(int unsigned d);
    int unsigned lim = 1;
    for (int k = 0; k < int'(d); k++) lim = lim * 10;
    return lim;
  endfunction

  function automatic logic [63:0] exp_bcd(int unsigned v, int unsigned d);
    logic [63:0] r = '0;
    int unsigned x = v;
    if (v >= limit_of(d)) begin
      for (int k = 0; k < int'(d); k++) r[4*k +: 4] = 4'h9;
    end else begin
      for (int k = 0; k < int'(d); k++) begin
        r[4*k +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of acceptance: idle for BW+2 cycles per conversion, start ignored while busy.
  always @(posedge clk) begin
    if (!reset_n) begin
      busy     <= 0;
      q.delete();
      rst_edge <= 1'b1;
      armed    <= 1'b1;
    end else begin
      rst_edge <= 1'b0;
      if (busy == 0) begin
        if (start) begin
          q.push_back('{mag_of(bin), neg_of(bin)});
          busy <= int'(BW) + 1;
        end
      end else begin
        busy <= busy - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      if (rst_edge) held = '{0, 1'b0};
      check("ready_a", 64'(ready_a), 64'(busy == 0));
      check("ready_b", 64'(ready_b), 64'(busy == 0));
      check("done_a", 64'(done_a), 64'(busy == 1));
      check("done_b", 64'(done_b), 64'(busy == 1));
      check("bcd_a", 64'(bcd_a), exp_bcd(held.mag, DA));
      check("bcd_b", 64'(bcd_b), exp_bcd(held.mag, DB));
      check("ovf_a", 64'(ovf_a), 64'(held.mag >= limit_of(DA)));
      check("ovf_b", 64'(ovf_b), 64'(held.mag >= limit_of(DB)));
      check("neg_a", 64'(neg_a), 64'(held.neg));
      check("neg_b", 64'(neg_b), 64'(held.neg));
      if (done_a) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done_tick expected no pending result at %0t", $time);
        end else begin
          held = q.pop_front();
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [BW-1:0] dir [7];

  initial begin
`ifdef BIN2BCD_SIGNED_EN
    dir = '{8'h80, 8'hFF, 8'h7F, 8'd0, 8'd99, 8'd100, 8'h9C};
`else
    dir = '{13'd8191, 13'd0, 13'd1000, 13'd999, 13'd1, 13'd100, 13'd4095};
`endif
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // Directed operands; bin scrambled and a stray start pulse during OP.
    for (int i = 0; i < 7; i++) begin
      bin   = dir[i];
      start = 1'b1;
      tick(1);
      start = 1'b0;
      bin   = BW'($urandom);
      tick(3);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(int'(BW));
    end

    // Reset in the middle of a conversion, then a fresh one.
    bin   = BW'(50);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(2);
    bin   = BW'(42);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(int'(BW) + 3);

    // Held start with bin changing every cycle: back-to-back conversions.
    start = 1'b1;
    repeat (40) begin
      bin = BW'($urandom);
      tick(1);
    end
    start = 1'b0;
    tick(int'(BW) + 3);

    // Random start pulses with occasional resets.
    repeat (400) begin
      bin     = BW'($urandom);
      start   = ($urandom % 3) == 0;
      reset_n = ($urandom % 150) != 0;
      tick(1);
    end
    reset_n = 1'b1;
    start   = 1'b0;
    tick(int'(BW) + 4);

    check("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_param.md
Name: bin2bcd_param

Overview:
Parametrised sequential binary-to-BCD converter (shift-and-add-3 / double dabble), generalising the fixed 13-bit/4-digit converter to arbitrary input width and digit count.
- Adds overflow detection with saturation, and an output register that holds the last result during conversion.
- Sits between a start source (debounced button or control FSM) and a digit display mux or UART formatter.

Parameters:
BIN_W, 13, binary input width in bits (>= 4)
DIGITS, 4, number of BCD output digits (>= 1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  conversion request, sampled only while ready=1
bin  input  BIN_W  binary operand, captured on the accepting edge
ready  output  1  high in IDLE; converter accepts start
done_tick  output  1  one-cycle pulse when new result is valid
overflow  output  1  value of last conversion exceeded 10^DIGITS-1
bcd  output  4*DIGITS  result, digit 0 in bits [3:0], most significant digit in top nibble

Behaviour:
- Reset (reset_n=0 at a clock edge; fully synchronous, no async path):
  - state=IDLE, ready=1, done_tick=0, overflow=0, bcd=0.
  - Internal shift and BCD working registers cleared; iteration counter cleared.
- FSM states: IDLE, OP, DONE.
- IDLE:
  - ready=1.
  - start=1 at edge -> latch bin into shift register, clear working BCD register and overflow sticky, load counter=BIN_W, go OP.
- OP, once per cycle:
  - Each working digit >= 5 gets +3 (all digits in parallel, combinational).
  - Then shift left by one: shift-register MSB enters working-BCD bit 0.
  - Any 1 shifted out of the top working digit sets the overflow sticky.
  - Counter decrements; after the BIN_W-th shift, go DONE.
- DONE (exactly one cycle), at its end:
  - If sticky set: bcd = all digits 9, overflow=1.
  - Else: bcd = working register, overflow=0.
  - done_tick=1 during DONE.
  - Go IDLE.
- Latency: start accepted at edge E -> done_tick high in the cycle after edge E+BIN_W; bcd/overflow valid from the edge ending DONE. Start-to-start throughput is BIN_W+2 cycles.
- ready=0 in OP and DONE; start asserted then is ignored, not queued. A held start triggers a new conversion on the first IDLE cycle.
- bcd/overflow change only at the DONE exit edge; they hold the previous result throughout OP.
- Changes on bin after the accepting edge have no effect.
- Reset mid-OP or mid-DONE: conversion aborted, outputs return to reset values, no done_tick.
- Counter width is clog2(BIN_W+1); no wrap in normal operation.

Optional Feature:
- Macro: BIN2BCD_SIGNED_EN
- Defined:
  - bin is two's complement. On acceptance the magnitude (|bin|, computed in BIN_W bits unsigned; -2^(BIN_W-1) maps to 2^(BIN_W-1)) is latched.
  - Extra output port neg (1 bit, reset 0) is loaded with bin's MSB at the DONE exit edge.
  - Overflow and saturation apply to the magnitude.
- Undefined: bin is unsigned, no neg port, behaviour as above.

Test Plan:
- Defaults, bin=8191, pulse start -> done_tick exactly 14 cycles after accept edge, bcd=16'h8191, overflow=0, ready back high the next cycle.
- bin=0 then bin=13'd1000 back-to-back -> bcd=16'h0000 then 16'h1000. A start pulse during OP is ignored: only two done_ticks.
- DIGITS=3, BIN_W=13, bin=1000 -> overflow=1, bcd=12'h999. Then bin=999 -> overflow=0, bcd=12'h999.
- reset_n low for one cycle at OP cycle 5 -> no done_tick, bcd=0, ready=1 next cycle. A new conversion of bin=42 then yields 16'h0042.
- bin changes every cycle during OP, start held high for 40 cycles -> each result equals the bin sampled at its accept edge, and bcd is stable between done_ticks.
- BIN2BCD_SIGNED_EN, BIN_W=8, DIGITS=3:
  - bin=8'h80 -> neg=1, bcd=12'h128.
  - bin=8'hFF -> neg=1, bcd=12'h001.
  - bin=8'h7F -> neg=0, bcd=12'h127.
